// File: rtl/nn_seq_pkg.sv
// nn_seq_pkg: command encoding, FSM state type and default sizes shared by
// the nn_load_sequencer block and its testbench.
package nn_seq_pkg;

  localparam int unsigned DEF_W_NIBBLES = 8;   // 32-bit weight register
  localparam int unsigned DEF_D_NIBBLES = 32;  // 128-bit data register
  localparam int unsigned DEF_N_W       = 4;   // terms per output
  localparam int unsigned DEF_N_OUT     = 4;   // outputs per run

  localparam logic [1:0] CMD_CLR = 2'b00;
  localparam logic [1:0] CMD_LDW = 2'b01;
  localparam logic [1:0] CMD_LDD = 2'b10;
  localparam logic [1:0] CMD_RUN = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_LOAD_D,
    ST_RUN,
    ST_FLUSH
  } state_e;

endpackage

// File: rtl/nn_seq_counter.sv
// nn_seq_counter: loadable up-counter with a terminal-count flag at LIMIT-1.
// Callers reload on terminal count, so the counter never wraps.
module nn_seq_counter #(
  parameter  int unsigned LIMIT = 16,
  localparam int unsigned CW    = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          en_i,
  output logic [CW-1:0] count_o,
  output logic          tc_o
);

  logic [CW-1:0] count_q, count_d;

  // NOTE: count_d gets its default before any branch, so no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    if (load_i)    count_d = load_val_i;
    else if (en_i) count_d = count_q + 1'b1;
  end

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == CW'(LIMIT - 1));

endmodule

// File: rtl/nn_load_sequencer.sv
// nn_load_sequencer: drives weight/data shift-register strobes from nibble commands and
// steps the MAC through an N_W x N_OUT dot-product schedule. Optional NN_SEQ_ABORT_EN adds abort.
module nn_load_sequencer
  import nn_seq_pkg::*;
#(
  parameter int unsigned W_NIBBLES = DEF_W_NIBBLES,
  parameter int unsigned D_NIBBLES = DEF_D_NIBBLES,  // must be >= W_NIBBLES
  parameter int unsigned N_W       = DEF_N_W,        // power of two
  parameter int unsigned N_OUT     = DEF_N_OUT
) (
  input  logic                           clk,
  input  logic                           rst,
`ifdef NN_SEQ_ABORT_EN
  input  logic                           abort,
`endif
  input  logic [1:0]                     cmd,
  input  logic                           cmd_valid,
  input  logic [3:0]                     nib_in,
  input  logic                           nib_valid,
  output logic [3:0]                     nib_out,
  output logic                           w_shift,
  output logic                           d_shift,
  output logic                           w_clr,
  output logic                           d_clr,
  output logic [$clog2(N_W)-1:0]         w_sel,
  output logic [$clog2(N_W*N_OUT)-1:0]   d_sel,
  output logic                           mac_clr,
  output logic                           mac_en,
  output logic                           out_valid,
  output logic [$clog2(N_OUT)-1:0]       out_idx,
  output logic                           busy,
  output logic                           w_loaded,
  output logic                           d_loaded,
  output logic                           err
);

  localparam int unsigned STEPS   = N_W * N_OUT;
  localparam int unsigned NIB_CW  = $clog2(D_NIBBLES);
  localparam int unsigned STEP_CW = $clog2(STEPS);
  localparam int unsigned W_SEL_W = $clog2(N_W);
  localparam int unsigned OUT_W   = $clog2(N_OUT);

  logic abort_req;
`ifdef NN_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  state_e             state_q, state_d;
  logic [3:0]         nib_out_q, nib_out_d;
  logic               w_shift_q, w_shift_d, d_shift_q, d_shift_d;
  logic               w_clr_q, w_clr_d, d_clr_q, d_clr_d;
  logic               out_valid_q, out_valid_d;
  logic [OUT_W-1:0]   out_idx_q, out_idx_d;
  logic               w_loaded_q, w_loaded_d, d_loaded_q, d_loaded_d;
  logic               err_q, err_d;

  logic               nib_load, nib_en, nib_tc;
  logic [NIB_CW-1:0]  nib_cnt;
  logic               step_load, step_en, step_tc;
  logic [STEP_CW-1:0] step_cnt;
  logic               nib_last, last_term;

  // One nibble counter serves both loads; D_NIBBLES sets its width and terminal count.
  nn_seq_counter #(.LIMIT(D_NIBBLES)) u_nib_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (nib_load),
    .load_val_i ('0),
    .en_i       (nib_en),
    .count_o    (nib_cnt),
    .tc_o       (nib_tc)
  );

  nn_seq_counter #(.LIMIT(STEPS)) u_step_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (step_load),
    .load_val_i ('0),
    .en_i       (step_en),
    .count_o    (step_cnt),
    .tc_o       (step_tc)
  );

  assign nib_last  = (state_q == ST_LOAD_W) ? (nib_cnt == NIB_CW'(W_NIBBLES - 1)) : nib_tc;
  assign last_term = (step_cnt[W_SEL_W-1:0] == W_SEL_W'(N_W - 1));

  always_comb begin
    state_d     = state_q;
    nib_out_d   = nib_out_q;
    w_shift_d   = 1'b0;
    d_shift_d   = 1'b0;
    w_clr_d     = 1'b0;
    d_clr_d     = 1'b0;
    out_valid_d = 1'b0;
    out_idx_d   = out_idx_q;
    w_loaded_d  = w_loaded_q;
    d_loaded_d  = d_loaded_q;
    err_d       = err_q;
    nib_load    = 1'b0;
    nib_en      = 1'b0;
    step_load   = 1'b0;
    step_en     = 1'b0;

    // Any command outside IDLE is dropped but remembered as an error.
    if (cmd_valid && state_q != ST_IDLE) err_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd)
            CMD_CLR: begin
              w_clr_d    = 1'b1;
              d_clr_d    = 1'b1;
              w_loaded_d = 1'b0;
              d_loaded_d = 1'b0;
              err_d      = 1'b0;
            end
            CMD_LDW: begin
              state_d    = ST_LOAD_W;
              w_clr_d    = 1'b1;
              w_loaded_d = 1'b0;
              nib_load   = 1'b1;
            end
            CMD_LDD: begin
              state_d    = ST_LOAD_D;
              d_clr_d    = 1'b1;
              d_loaded_d = 1'b0;
              nib_load   = 1'b1;
            end
            default: begin
              if (w_loaded_q && d_loaded_q) begin
                state_d   = ST_RUN;
                step_load = 1'b1;
              end else begin
                err_d = 1'b1;
              end
            end
          endcase
        end
      end

      ST_LOAD_W, ST_LOAD_D: begin
        if (abort_req) begin
          state_d  = ST_IDLE;
          nib_load = 1'b1;
        end else if (nib_valid) begin
          nib_out_d = nib_in;
          w_shift_d = (state_q == ST_LOAD_W);
          d_shift_d = (state_q == ST_LOAD_D);
          if (nib_last) begin
            state_d  = ST_IDLE;
            nib_load = 1'b1;
            if (state_q == ST_LOAD_W) w_loaded_d = 1'b1;
            else                      d_loaded_d = 1'b1;
          end else begin
            nib_en = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (abort_req) begin
          state_d   = ST_IDLE;
          step_load = 1'b1;
        end else begin
          // The group result is valid the cycle after its last term accumulates.
          if (last_term) begin
            out_valid_d = 1'b1;
            out_idx_d   = OUT_W'(step_cnt >> W_SEL_W);
          end
          if (step_tc) begin
            state_d   = ST_FLUSH;
            step_load = 1'b1;
          end else begin
            step_en = 1'b1;
          end
        end
      end

      ST_FLUSH: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      nib_out_q   <= '0;
      w_shift_q   <= 1'b0;
      d_shift_q   <= 1'b0;
      w_clr_q     <= 1'b0;
      d_clr_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      w_loaded_q  <= 1'b0;
      d_loaded_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      nib_out_q   <= nib_out_d;
      w_shift_q   <= w_shift_d;
      d_shift_q   <= d_shift_d;
      w_clr_q     <= w_clr_d;
      d_clr_q     <= d_clr_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      w_loaded_q  <= w_loaded_d;
      d_loaded_q  <= d_loaded_d;
      err_q       <= err_d;
    end
  end

  assign nib_out   = nib_out_q;
  assign w_shift   = w_shift_q;
  assign d_shift   = d_shift_q;
  assign w_clr     = w_clr_q;
  assign d_clr     = d_clr_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign w_loaded  = w_loaded_q;
  assign d_loaded  = d_loaded_q;
  assign err       = err_q;

  assign busy    = (state_q != ST_IDLE);
  assign mac_en  = (state_q == ST_RUN);
  assign mac_clr = mac_en && (step_cnt[W_SEL_W-1:0] == '0);
  assign w_sel   = mac_en ? step_cnt[W_SEL_W-1:0] : '0;
  assign d_sel   = mac_en ? step_cnt : '0;

endmodule

// File: tb/tb_nn_load_sequencer.sv
// tb_nn_load_sequencer: directed sequence with random payload and gaps, checked against
// a rule-level model of flags and the run schedule. Define NN_SEQ_ABORT_EN to cover abort.
module tb_nn_load_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] cmd;
  logic       cmd_valid;
  logic [3:0] nib_in;
  logic       nib_valid;
  logic [3:0] nib_out;
  logic       w_shift, d_shift, w_clr, d_clr;
  logic [1:0] w_sel;
  logic [3:0] d_sel;
  logic       mac_clr, mac_en, out_valid;
  logic [1:0] out_idx;
  logic       busy, w_loaded, d_loaded, err;
`ifdef NN_SEQ_ABORT_EN
  logic       abort;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state: flags derived from the command rules.
  bit         m_busy, m_wl, m_dl, m_err;
  logic [3:0] nib_q[$];

  nn_load_sequencer dut (
    .clk       (clk),
    .rst       (rst),
`ifdef NN_SEQ_ABORT_EN
    .abort     (abort),
`endif
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .nib_in    (nib_in),
    .nib_valid (nib_valid),
    .nib_out   (nib_out),
    .w_shift   (w_shift),
    .d_shift   (d_shift),
    .w_clr     (w_clr),
    .d_clr     (d_clr),
    .w_sel     (w_sel),
    .d_sel     (d_sel),
    .mac_clr   (mac_clr),
    .mac_en    (mac_en),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .busy      (busy),
    .w_loaded  (w_loaded),
    .d_loaded  (d_loaded),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string tag);
    check({tag, ".busy"},     busy,     m_busy);
    check({tag, ".w_loaded"}, w_loaded, m_wl);
    check({tag, ".d_loaded"}, d_loaded, m_dl);
    check({tag, ".err"},      err,      m_err);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".nib_out"},   nib_out,   0);
    check({tag, ".w_shift"},   w_shift,   0);
    check({tag, ".d_shift"},   d_shift,   0);
    check({tag, ".w_clr"},     w_clr,     0);
    check({tag, ".d_clr"},     d_clr,     0);
    check({tag, ".w_sel"},     w_sel,     0);
    check({tag, ".d_sel"},     d_sel,     0);
    check({tag, ".mac_clr"},   mac_clr,   0);
    check({tag, ".mac_en"},    mac_en,    0);
    check({tag, ".out_valid"}, out_valid, 0);
    check({tag, ".out_idx"},   out_idx,   0);
    check_flags(tag);
  endtask

  // Issue a command while idle; the model applies the command table.
  task automatic issue(input logic [1:0] c);
    bit exp_wclr, exp_dclr;
    exp_wclr = 0;
    exp_dclr = 0;
    case (c)
      2'b00: begin exp_wclr = 1; exp_dclr = 1; m_wl = 0; m_dl = 0; m_err = 0; end
      2'b01: begin exp_wclr = 1; m_wl = 0; m_busy = 1; end
      2'b10: begin exp_dclr = 1; m_dl = 0; m_busy = 1; end
      default: begin
        if (m_wl && m_dl) m_busy = 1;
        else              m_err  = 1;
      end
    endcase
    cmd = c;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("cmd.w_clr", w_clr, exp_wclr);
    check("cmd.d_clr", d_clr, exp_dclr);
    check_flags("cmd");
  endtask

  task automatic load(input bit is_w, input bit counting, input int err_at, input int abort_at);
    int n;
    logic [3:0] v, exp_v;
    n = is_w ? 8 : 32;
    issue(is_w ? 2'b01 : 2'b10);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        tick();
        check("gap.w_shift", w_shift, 0);
        check("gap.d_shift", d_shift, 0);
        check_flags("gap");
      end
`ifdef NN_SEQ_ABORT_EN
      if (i == abort_at) begin
        abort = 1'b1;
        nib_valid = 1'b1;
        nib_in = 4'($urandom_range(0, 15));
        tick();
        abort = 1'b0;
        nib_valid = 1'b0;
        m_busy = 0;
        if (is_w) m_wl = 0;
        else      m_dl = 0;
        check("abort_ld.w_shift", w_shift, 0);
        check("abort_ld.d_shift", d_shift, 0);
        check_flags("abort_ld");
        nib_q.delete();
        return;
      end
`endif
      v = counting ? 4'(i + 1) : 4'($urandom_range(0, 15));
      nib_q.push_back(v);
      nib_in = v;
      nib_valid = 1'b1;
      if (i == err_at) begin
        cmd = 2'($urandom_range(0, 3));
        cmd_valid = 1'b1;
        m_err = 1;
      end
      tick();
      nib_valid = 1'b0;
      cmd_valid = 1'b0;
      if (i == n - 1) begin
        m_busy = 0;
        if (is_w) m_wl = 1;
        else      m_dl = 1;
      end
      exp_v = nib_q.pop_front();
      check("load.w_shift", w_shift, is_w);
      check("load.d_shift", d_shift, !is_w);
      check("load.nib_out", nib_out, exp_v);
      check_flags("load");
    end
    tick();
    check("post.w_shift", w_shift, 0);
    check("post.d_shift", d_shift, 0);
    check_flags("post");
  endtask

  // Cycle c (1-based, after the command edge) of a run: c<=16 is step c-1, c=17 is flush.
  task automatic run(input int err_at, input int cut_at, input bit by_abort);
    issue(2'b11);
    for (int c = 1; c <= 17; c++) begin
      int s;
      bit ov;
      s  = c - 1;
      ov = (c >= 5) && (c % 4 == 1);
      check("run.mac_en", mac_en, (c <= 16));
      if (c <= 16) begin
        check("run.w_sel",   w_sel,   s % 4);
        check("run.d_sel",   d_sel,   s);
        check("run.mac_clr", mac_clr, (s % 4 == 0));
      end
      check("run.out_valid", out_valid, ov);
      if (ov) check("run.out_idx", out_idx, (c - 5) / 4);
      check_flags("run");
      if (s == cut_at) begin
        if (by_abort) begin
`ifdef NN_SEQ_ABORT_EN
          abort = 1'b1;
          tick();
          abort = 1'b0;
          m_busy = 0;
          check("abort_run.mac_en", mac_en, 0);
          check_flags("abort_run");
          for (int k = 0; k < 14; k++) begin
            check("abort_run.out_valid", out_valid, 0);
            tick();
          end
`endif
        end else begin
          rst = 1'b1;
          #1;
          m_busy = 0; m_wl = 0; m_dl = 0; m_err = 0;
          check_all_zero("mid_rst");
          @(posedge clk);
          #1;
          rst = 1'b0;
          tick();
          check_all_zero("after_rst");
        end
        return;
      end
      if (c == err_at) begin
        cmd = 2'($urandom_range(0, 3));
        cmd_valid = 1'b1;
      end
      tick();
      cmd_valid = 1'b0;
      if (c == err_at) m_err = 1;
      if (c == 17)     m_busy = 0;
    end
    check("end.mac_en",    mac_en,    0);
    check("end.out_valid", out_valid, 0);
    check_flags("end");
  endtask

  initial begin
    rst = 1'b1;
    cmd = 2'b00;
    cmd_valid = 1'b0;
    nib_in = 4'h0;
    nib_valid = 1'b0;
`ifdef NN_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    m_busy = 0; m_wl = 0; m_dl = 0; m_err = 0;

    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check_all_zero("idle");

    // Run with nothing loaded is an error; clear recovers it with one-cycle pulses.
    issue(2'b11);
    issue(2'b00);
    tick();
    check("clr_pulse.w_clr", w_clr, 0);
    check("clr_pulse.d_clr", d_clr, 0);

    load(1'b1, 1'b1, -1, -1);

    // Payload outside a load is ignored without error.
    nib_in = 4'($urandom_range(0, 15));
    nib_valid = 1'b1;
    tick();
    nib_valid = 1'b0;
    check("idle_nib.w_shift", w_shift, 0);
    check("idle_nib.d_shift", d_shift, 0);
    check_flags("idle_nib");

    load(1'b0, 1'b0, -1, -1);
    run(-1, -1, 1'b0);
    run(9, -1, 1'b0);

    issue(2'b00);
    load(1'b1, 1'b0, 3, -1);
    load(1'b0, 1'b0, -1, -1);
    run(-1, 6, 1'b0);

`ifdef NN_SEQ_ABORT_EN
    load(1'b1, 1'b0, -1, -1);
    load(1'b0, 1'b0, -1, -1);
    run(-1, 6, 1'b1);
    load(1'b1, 1'b0, -1, 3);
    issue(2'b11);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
